// File: rtl/run_halt_if.sv
// Run/halt controller signal bundle: panel/decode inputs and pipeline control outputs.
interface run_halt_if;
  logic       exec;
  logic       halt_id;
  logic       in_id;
  logic       step_mode;
  logic       running;
  logic       pc_write;
  logic       if_flush;
  logic       press;
  logic [1:0] stop_cause;
  logic       halt_inflight;

  // Core/panel side: drives decode and switch inputs, consumes control.
  modport master (
    output exec, halt_id, in_id, step_mode,
    input  running, pc_write, if_flush, press, stop_cause, halt_inflight
  );

  // Controller side.
  modport slave (
    input  exec, halt_id, in_id, step_mode,
    output running, pc_write, if_flush, press, stop_cause, halt_inflight
  );
endinterface

// File: rtl/run_halt_controller.sv
// Run/stop sequencer for the pipelined SIMPLE core: debounces the exec switch
// into a run toggle, tracks HLT through the post-decode stages and stops on
// HLT retirement or IN reaching EX. Optional feature macro: SINGLE_STEP_EN
// (a press while stopped with step_mode=1 runs exactly one cycle).
module run_halt_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 15,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned PIPE_DEPTH      = 3
) (
  input  logic          clock,
  input  logic          reset,
  run_halt_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_HLT  = 2'b01;
  localparam logic [1:0] CAUSE_IN   = 2'b10;
`ifdef SINGLE_STEP_EN
  localparam logic [1:0] CAUSE_STEP = 2'b11;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  state_e                r_state;
  logic                  r_exec_q;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_press;
  logic [1:0]            r_cause;
  logic [PIPE_DEPTH-1:0] r_hsr;
  logic                  r_in_ex;

  state_e                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_press_nxt;
  logic [1:0]            w_cause_nxt;
  logic [PIPE_DEPTH-1:0] w_hsr_nxt;
  logic                  w_in_ex_nxt;

  logic                  w_running;
  logic                  w_halt_stop;
  logic                  w_in_stop;
  logic                  w_halt_inflight;

`ifndef SINGLE_STEP_EN
  logic                  w_unused_step;
  assign w_unused_step = bus.step_mode;
`endif

  assign w_running       = (r_state != ST_STOP);
  assign w_halt_stop     = w_running & r_hsr[PIPE_DEPTH-1];
  assign w_in_stop       = w_running & r_in_ex;
  assign w_halt_inflight = bus.halt_id | (|r_hsr);

  assign bus.running       = w_running;
  assign bus.halt_inflight = w_halt_inflight;
  assign bus.if_flush      = w_halt_inflight;
  assign bus.pc_write      = w_running & ~w_halt_inflight;
  assign bus.press         = r_press;
  assign bus.stop_cause    = r_cause;

  // Debounce: count stable cycles after a level change, pulse press on a stable 1.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    if (bus.exec != r_exec_q) begin
      w_cnt_nxt = CNT_ONE;
    end else if (r_cnt == '0) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CNT_MAX) begin
      w_cnt_nxt   = '0;
      w_press_nxt = bus.exec;
    end else begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end
  end

  // HLT shift register and IN-in-EX flag advance only while the pipe runs.
  always_comb begin
    w_hsr_nxt   = r_hsr;
    w_in_ex_nxt = r_in_ex;
    if (w_halt_stop) begin
      w_hsr_nxt = '0;
    end else if (w_running) begin
      w_hsr_nxt[0] = bus.halt_id;
      for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
        w_hsr_nxt[i] = r_hsr[i-1];
      end
    end
    if (w_in_stop) begin
      w_in_ex_nxt = 1'b0;
    end else if (w_running) begin
      w_in_ex_nxt = bus.in_id;
    end
  end

  // Run state: HLT retire, then IN stop, then step end, then press toggle.
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    if (w_halt_stop) begin
      w_state_nxt = ST_STOP;
      w_cause_nxt = CAUSE_HLT;
    end else if (w_in_stop) begin
      w_state_nxt = ST_STOP;
      w_cause_nxt = CAUSE_IN;
`ifdef SINGLE_STEP_EN
    end else if (r_state == ST_STEP) begin
      w_state_nxt = ST_STOP;
      w_cause_nxt = CAUSE_STEP;
`endif
    end else if (r_press) begin
      if (w_running) begin
        w_state_nxt = ST_STOP;
        w_cause_nxt = CAUSE_NONE;
      end else begin
`ifdef SINGLE_STEP_EN
        w_state_nxt = bus.step_mode ? ST_STEP : ST_RUN;
`else
        w_state_nxt = ST_RUN;
`endif
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_STOP;
      r_exec_q <= bus.exec;
      r_cnt    <= '0;
      r_press  <= 1'b0;
      r_cause  <= CAUSE_NONE;
      r_hsr    <= '0;
      r_in_ex  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_exec_q <= bus.exec;
      r_cnt    <= w_cnt_nxt;
      r_press  <= w_press_nxt;
      r_cause  <= w_cause_nxt;
      r_hsr    <= w_hsr_nxt;
      r_in_ex  <= w_in_ex_nxt;
    end
  end

endmodule

// File: tb/tb_run_halt_controller.sv
// Randomized bench for run_halt_controller against a run-length / HLT-age reference model.
module tb_run_halt_controller;

  localparam int unsigned DEB = 15;
  localparam int unsigned PD  = 3;

  logic clock;
  logic reset;

  run_halt_if rh_if ();

  run_halt_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (16),
    .PIPE_DEPTH      (PD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (rh_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks;
  int unsigned n_fail;

  // Reference model state.
  bit          m_running;
  bit          m_step;
  logic [1:0]  m_cause;
  bit          m_press;
  bit          m_in_ex;
  bit          m_prev_exec;
  int unsigned m_run_len;
  int          m_hq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees.
  task automatic model_step();
    bit         hstop;
    bit         istop;
    bit         nrun;
    bit         nstep;
    logic [1:0] ncause;
    bit         npress;
    if (reset) begin
      m_running   = 1'b0;
      m_step      = 1'b0;
      m_cause     = 2'b00;
      m_press     = 1'b0;
      m_in_ex     = 1'b0;
      m_prev_exec = rh_if.exec;
      m_run_len   = 0;
      m_hq.delete();
      return;
    end
    // Run length of the current exec level, counted from a real change only.
    if (rh_if.exec != m_prev_exec) m_run_len = 1;
    else if (m_run_len != 0) m_run_len++;
    m_prev_exec = rh_if.exec;
    npress = (m_run_len == DEB + 1) && rh_if.exec;

    hstop = 1'b0;
    foreach (m_hq[k]) if (m_hq[k] == int'(PD) - 1) hstop = m_running;
    istop = m_running && m_in_ex;

    if (istop) m_in_ex = 1'b0;
    else if (m_running) m_in_ex = rh_if.in_id;

    if (hstop) m_hq.delete();
    else if (m_running) begin
      foreach (m_hq[k]) m_hq[k]++;
      if (rh_if.halt_id) m_hq.push_back(0);
    end

    nrun = m_running; nstep = m_step; ncause = m_cause;
    if (hstop) begin
      nrun = 1'b0; nstep = 1'b0; ncause = 2'b01;
    end else if (istop) begin
      nrun = 1'b0; nstep = 1'b0; ncause = 2'b10;
    end else if (m_step) begin
      nrun = 1'b0; nstep = 1'b0; ncause = 2'b11;
    end else if (m_press) begin
      if (m_running) begin
        nrun = 1'b0; ncause = 2'b00;
      end else begin
        nrun = 1'b1;
`ifdef SINGLE_STEP_EN
        nstep = rh_if.step_mode;
`else
        nstep = 1'b0;
`endif
      end
    end
    m_running = nrun;
    m_step    = nstep;
    m_cause   = ncause;
    m_press   = npress;
  endtask

  task automatic compare_all();
    bit inflight;
    inflight = rh_if.halt_id || (m_hq.size() != 0);
    check("running",       32'(rh_if.running),       32'(m_running));
    check("press",         32'(rh_if.press),         32'(m_press));
    check("stop_cause",    32'(rh_if.stop_cause),    32'(m_cause));
    check("halt_inflight", 32'(rh_if.halt_inflight), 32'(inflight));
    check("if_flush",      32'(rh_if.if_flush),      32'(inflight));
    check("pc_write",      32'(rh_if.pc_write),      32'(m_running && !inflight));
  endtask

  // One clock: DUT and model take the edge, outputs compared 1 time unit later.
  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      model_step();
      #1;
      compare_all();
      @(negedge clock);
    end
  endtask

  task automatic press_exec();
    rh_if.exec = 1'b0; tick(20);
    rh_if.exec = 1'b1; tick(20);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    rh_if.exec = 1'b0; rh_if.halt_id = 1'b0; rh_if.in_id = 1'b0; rh_if.step_mode = 1'b0;
    tick(2);
    rh_if.halt_id = 1'b1; tick(1);
    rh_if.halt_id = 1'b0;
    reset = 1'b0;

    // Clean press: exec held high after reset.
    rh_if.exec = 1'b1; tick(20);
    tick(5);
    // HLT retire while running.
    rh_if.halt_id = 1'b1; tick(1);
    rh_if.halt_id = 1'b0; tick(8);
    // Bouncing switch: no press.
    rh_if.exec = 1'b0; tick(5);
    for (int t = 0; t < 8; t++) begin
      rh_if.exec = ~rh_if.exec; tick(5);
    end
    // Resume, then IN stop, then resume again.
    press_exec();
    if (!m_running) press_exec();
    rh_if.in_id = 1'b1; tick(1);
    rh_if.in_id = 1'b0; tick(5);
    press_exec();
    tick(10);
    // Reset while a HLT is in flight.
    rh_if.halt_id = 1'b1; tick(1);
    rh_if.halt_id = 1'b0; reset = 1'b1; tick(1);
    reset = 1'b0; tick(3);
    // Single step attempt (a normal run when the feature is absent).
    rh_if.step_mode = 1'b1;
    press_exec();
    tick(5);
    rh_if.step_mode = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(29, 0) == 0) rh_if.exec = ~rh_if.exec;
      rh_if.halt_id = ($urandom_range(15, 0) == 0);
      rh_if.in_id   = ($urandom_range(15, 0) == 0);
      if ($urandom_range(49, 0) == 0) rh_if.step_mode = ~rh_if.step_mode;
      reset = ($urandom_range(399, 0) == 0);
      tick(1);
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
